// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: sequences MOVE / LOAD_IMM / READ transfers between a register file and a shared bus
module bus_transfer_controller #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 4
) (
  input  logic                  bus_ctrl_clock,
  input  logic                  bus_ctrl_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] register_addr,
  output logic                  bus_register_input_en,
  output logic                  bus_register_out_en,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_drive_en,
  output logic [15:0]           xfer_count
);
  typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);
  state_t state, next_state;
  logic [1:0] op;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [DATA_WIDTH-1:0] data, bus_out, rsp_q;
  logic err, accept, cmd_err;
  assign accept = cmd_valid && state == IDLE;
  assign cmd_err = cmd_op == 2'b11
    || (cmd_op != 2'b01 && {1'b0, cmd_src} >= REG_LIMIT)
    || (cmd_op != 2'b10 && {1'b0, cmd_dst} >= REG_LIMIT)
    || (cmd_op == 2'b00 && cmd_src == cmd_dst);
  assign bus_data_out = bus_out;
  assign rsp_data = rsp_q;
  // state register; reset aborts any command in flight
  always_ff @(posedge bus_ctrl_clock or negedge bus_ctrl_reset_n)
    if (!bus_ctrl_reset_n) state <= IDLE;
    else state <= next_state;
  // sequencing: errors skip the bus, LOAD_IMM skips the read, only MOVE needs the turnaround
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:  next_state = !accept ? IDLE : cmd_err ? DONE : cmd_op == 2'b01 ? WRITE : READ;
      READ:  next_state = op == 2'b00 ? TURN : DONE;
      TURN:  next_state = WRITE;
      WRITE: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end
  // bus and response outputs decoded purely from registered state
  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == DONE;
    rsp_error = state == DONE && err;
    register_addr = (state == READ || state == TURN) ? src : state == WRITE ? dst : '0;
    bus_register_out_en = state == READ;
    bus_register_input_en = state == WRITE;
    bus_drive_en = state == WRITE;
  end
  // command latch and data register; read data captured on the edge ending READ
  always_ff @(posedge bus_ctrl_clock or negedge bus_ctrl_reset_n)
    if (!bus_ctrl_reset_n) begin
      op <= '0;
      src <= '0;
      dst <= '0;
      err <= 1'b0;
      data <= '0;
    end else if (accept) begin
      op <= cmd_op;
      src <= cmd_src;
      dst <= cmd_dst;
      err <= cmd_err;
      data <= cmd_imm;
    end else if (state == READ) data <= bus_data_in;
  // bus value, response value and completion counter; each holds until its next update
  always_ff @(posedge bus_ctrl_clock or negedge bus_ctrl_reset_n)
    if (!bus_ctrl_reset_n) begin
      bus_out <= '0;
      rsp_q <= '0;
      xfer_count <= '0;
    end else begin
      if (next_state == WRITE) bus_out <= state == IDLE ? cmd_imm : data;
      if (next_state == DONE) rsp_q <= state == IDLE ? '0 : state == READ ? bus_data_in : data;
      if (state == DONE && !err) xfer_count <= xfer_count + 16'd1;
    end
endmodule

// File: tb/tb_bus_transfer_controller.sv
// tb_bus_transfer_controller: directed and random commands against a transaction-level reference model
module tb_bus_transfer_controller;
  localparam int AW = 6, DW = 16, NR = 4;
  logic clk = 1'b0, rst_n = 1'b0, env_up = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_error;
  logic bus_register_input_en, bus_register_out_en, bus_drive_en;
  logic [1:0] cmd_op = '0;
  logic [AW-1:0] cmd_src = '0, cmd_dst = '0, register_addr;
  logic [DW-1:0] cmd_imm = '0, rsp_data, bus_data_in, bus_data_out, noise = '0;
  logic [15:0] xfer_count;
  logic [DW-1:0] env_regs [NR];
  logic [DW-1:0] ref_regs [NR];
  logic [15:0] ref_count = '0;
  logic [DW-1:0] ref_bus = '0, ref_rsp = '0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  bus_transfer_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .bus_ctrl_clock(clk), .bus_ctrl_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .register_addr(register_addr), .bus_register_input_en(bus_register_input_en),
    .bus_register_out_en(bus_register_out_en), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_drive_en(bus_drive_en), .xfer_count(xfer_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // external register file the controller talks to; reset value {0,1,2,3}
  always @(posedge clk)
    if (!env_up) for (int i = 0; i < NR; i++) env_regs[i] <= DW'(i);
    else if (bus_register_input_en && register_addr < AW'(NR)) env_regs[register_addr[1:0]] <= bus_data_out;

  assign bus_data_in = bus_register_out_en ? env_regs[register_addr[1:0]] : noise;

  always @(negedge clk) begin
    noise <= DW'($urandom);
    if (rst_n) check("bus_exclusive", {31'd0, bus_register_out_en & bus_drive_en}, 32'd0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_regs();
    for (int i = 0; i < NR; i++) check("regfile", {16'd0, env_regs[i]}, {16'd0, ref_regs[i]});
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                        input logic [DW-1:0] imm);
    bit err;
    string ph;
    logic [DW-1:0] val;
    logic [AW-1:0] a_e;
    logic [5:0] f_e;
    for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge clk);
    check("ready_before", {31'd0, cmd_ready}, 32'd1);
    err = op == 2'b11 || (op != 2'b01 && src >= AW'(NR)) || (op != 2'b10 && dst >= AW'(NR))
          || (op == 2'b00 && src == dst);
    ph = err ? "D" : op == 2'b01 ? "WD" : op == 2'b10 ? "RD" : "RTWD";
    val = err ? '0 : op == 2'b01 ? imm : ref_regs[src[1:0]];
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
    @(posedge clk);
    #1;
    for (int k = 0; k < ph.len(); k++) begin
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_src = AW'($urandom);
      cmd_dst = AW'($urandom); cmd_imm = DW'($urandom);
      @(negedge clk);
      a_e = ph[k] == "R" || ph[k] == "T" ? src : ph[k] == "W" ? dst : '0;
      f_e = ph[k] == "R" ? 6'b100000 : ph[k] == "W" ? 6'b011000 : ph[k] == "D" ? {4'b0001, err, 1'b0} : 6'b0;
      check($sformatf("phase_%s_op%0d", ph.substr(k, k), op),
            {20'd0, register_addr, bus_register_out_en, bus_register_input_en, bus_drive_en,
             rsp_valid, rsp_error, cmd_ready}, {20'd0, a_e, f_e});
      check("bus_data_out", {16'd0, bus_data_out}, {16'd0, ph[k] == "W" ? val : ref_bus});
      check("rsp_data", {16'd0, rsp_data}, {16'd0, ph[k] == "D" ? val : ref_rsp});
      if (ph[k] == "W") ref_bus = val;
      if (ph[k] == "D") cmd_valid = 1'b0;
    end
    ref_rsp = val;
    if (!err) begin
      ref_count++;
      if (op != 2'b10) ref_regs[dst[1:0]] = val;
    end
    @(negedge clk);
    check("idle_after", {15'd0, rsp_valid, rsp_error, cmd_ready, xfer_count},
          {15'd0, 1'b0, 1'b0, 1'b1, ref_count});
    check_regs();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) ref_regs[i] = DW'(i);
    #12;
    check("reset_outputs", {7'd0, cmd_ready, rsp_valid, rsp_error, register_addr,
          bus_register_input_en, bus_register_out_en, bus_drive_en, xfer_count},
          {7'd0, 1'b1, 1'b0, 1'b0, 6'd0, 3'b000, 16'd0});
    check("reset_data", {rsp_data, bus_data_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    env_up = 1'b1;
    @(negedge clk);
    do_cmd(2'b01, 6'd0, 6'd2, 16'hBEEF);
    do_cmd(2'b00, 6'd2, 6'd0, 16'h1234);
    do_cmd(2'b10, 6'd3, 6'd0, 16'h5555);
    do_cmd(2'b11, 6'd0, 6'd1, 16'h7777);
    do_cmd(2'b00, 6'd5, 6'd1, 16'h7777);
    do_cmd(2'b00, 6'd1, 6'd1, 16'h7777);
    do_cmd(2'b01, 6'd0, 6'd4, 16'h7777);
    do_cmd(2'b10, 6'd63, 6'd0, 16'h7777);
    do_cmd(2'b01, 6'd0, 6'd3, 16'hA5A5);
    // MOVE aborted by reset while in the turnaround cycle
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src = 6'd3; cmd_dst = 6'd1; cmd_imm = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("turn_state", {25'd0, register_addr, bus_register_out_en}, {25'd0, 6'd3, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {7'd0, cmd_ready, rsp_valid, rsp_error, register_addr,
          bus_register_input_en, bus_register_out_en, bus_drive_en, xfer_count},
          {7'd0, 1'b1, 1'b0, 1'b0, 6'd0, 3'b000, 16'd0});
    check("abort_data", {rsp_data, bus_data_out}, 32'd0);
    ref_count = '0; ref_bus = '0; ref_rsp = '0;
    @(negedge clk);
    check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    check_regs();
    do_cmd(2'b01, 6'd0, 6'd1, 16'h0F0F);
    // counter wrap: preload near the top, then complete a few commands
    @(negedge clk);
    force dut.xfer_count = 16'hFFFE;
    @(negedge clk);
    release dut.xfer_count;
    ref_count = 16'hFFFE;
    do_cmd(2'b01, 6'd0, 6'd2, 16'h1111);
    do_cmd(2'b01, 6'd0, 6'd2, 16'h2222);
    do_cmd(2'b11, 6'd0, 6'd2, 16'h3333);
    do_cmd(2'b10, 6'd2, 6'd0, 16'h3333);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_cmd(2'($urandom), AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5)), DW'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
